pic_cmd_sequencer: RTL and testbench
====================================

# pic_cmd_sequencer

Clocked command sequencer for the 8259A-style PIC. It samples the CPU write strobe, address bit A0 and the data bus, then classifies each write as ICW1–ICW4 or OCW1–OCW3. It tracks the initialization sequence (ICW1 → ICW2 → optional ICW3 → optional ICW4 → ready) and forwards each accepted command to the control logic as a one-cycle strobe with its command code and data byte. Writes that are illegal in the current state are dropped and flagged.

## Interface
- `CASCADE_EN`, default 1: when 0, ICW3 is never expected, even with SNGL=0.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cs_n` in 1: chip select, active-low, synchronous to clk.
- `wr_n` in 1: write strobe, active-low, synchronous to clk.
- `a0` in 1: command address bit.
- `din` in 8: CPU data bus.
- `cmd_valid` out 1: one-cycle pulse, command accepted.
- `cmd_code` out 3: ICW1=000, ICW2=001, ICW3=010, ICW4=011, OCW1=100, OCW2=101, OCW3=110.
- `cmd_data` out 8: data byte of the accepted command.
- `no_icw4` out 1: ~ICW1.D0; the control logic applies ICW4 defaults.
- `sngl` out 1: ICW1.D1.
- `init_busy` out 1: initialization sequence in progress.
- `ready` out 1: initialization complete; OCWs accepted.
- `seq_err` out 1: one-cycle pulse, write dropped.

## Operation
- Input stage registers `cs_n`, `wr_n`, `a0` and `din` every cycle (`cs_q`, `wr_q`, `a0_q`, `din_q`).
- Write event: `wr_q`=0 && `cs_q`=0 && `wr_n`=1. The data used is `a0_q`/`din_q`, the last values sampled while the strobe was low.
- ICW1 detect: `a0_q`=0 && `din_q`[4]=1. It is accepted in every state and restarts the sequence.
  - Latches `no_icw4` = ~`din_q`[0] and `sngl` = `din_q`[1].
  - Next state: WAIT_ICW2.
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- IDLE: any non-ICW1 write → `seq_err`.
- WAIT_ICW2:
  - a0=1 → ICW2 emitted.
  - Next state: WAIT_ICW3 if `sngl`=0 && `CASCADE_EN`; else WAIT_ICW4 if `no_icw4`=0; else READY.
- WAIT_ICW3: a0=1 → ICW3 emitted; next state WAIT_ICW4 if `no_icw4`=0, else READY.
- WAIT_ICW4: a0=1 → ICW4 emitted; next state READY.
- WAIT_* states: a0=0 with `din_q`[4]=0 → `seq_err`, state unchanged, nothing emitted.
- READY decode:
  - a0=1 → OCW1.
  - a0=0, D4=0, D3=0 → OCW2.
  - a0=0, D4=0, D3=1 → OCW3.
- `init_busy` = 1 in WAIT_ICW2/3/4. `ready` = 1 in READY.
- Emitted commands set `cmd_code`/`cmd_data`. These hold their value until the next emitted command.

## Timing
- Reset values: `cmd_valid`=0, `cmd_code`=000, `cmd_data`=00h, `no_icw4`=1, `sngl`=1, `init_busy`=0, `ready`=0, `seq_err`=0; state IDLE.
- Latency: `cmd_valid`/`seq_err` rise on the clk edge at which `wr_n` is first sampled high after being sampled low; they are high for exactly one cycle.
- State, `no_icw4` and `sngl` update on the same edge as the strobe.
- Minimum write spacing: `wr_n` low ≥1 sample and high ≥1 sample, i.e. one write per 2 cycles.
- `cs_n` deasserting on the same edge that `wr_n` rises: the write is still accepted, because `cs_q` is used.
- `cs_n` high during the low phase: no event.
- ICW1 mid-init or in READY: acts as a restart; `cmd_valid` pulses with code 000. There is no `seq_err`.
- `rst_n` low mid-write: all state and outputs return to reset values immediately. The pending write is lost, and no event fires on release even if `wr_n` rises later. This is because `wr_q` resets to 1.

## Structure
- Shared package `pic_pkg`: command-code localparams (ICW1..OCW3, matching the control logic's WR_cur encoding) and state encodings.
- Sub-module `pic_wr_edge`: input registers and write-event detect. It outputs `wr_evt`, `a0_q` and `din_q`.
- The FSM and output registers live in the top module.

## Test plan
- Reset, then ICW1=13h (SNGL=1, IC4=1), ICW2 (a0=1, A8h), ICW4 (a0=1, 03h) → codes 000, 001, 011, one `cmd_valid` each; `ready`=1 after ICW4; `no_icw4`=0, `sngl`=1.
- ICW1=11h (cascade, IC4) with `CASCADE_EN`=1 → three a0=1 writes emit 001, 010, 011; with `CASCADE_EN`=0 the third write is OCW1 (100).
- In READY: writes a0=1/02h, a0=0/20h, a0=0/0Bh → 100/02h, 101/20h, 110/0Bh.
- Write a0=1/FFh in IDLE → `seq_err` pulse, no `cmd_valid`, state IDLE. Write a0=0/20h in WAIT_ICW2 → `seq_err`, state held.
- ICW1 during WAIT_ICW3 → restart to WAIT_ICW2. Assert `rst_n` while `wr_n`=0 → all outputs at reset values, and no event after release.
- Back-to-back writes at 2-cycle spacing → every write emitted; `cs_n` rising on the same edge as `wr_n` → write still accepted.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command sequencer: command codes, FSM states
// and the ICW1 pattern test used wherever a write is classified.
package pic_pkg;

  localparam logic [2:0] CMD_ICW1 = 3'b000;
  localparam logic [2:0] CMD_ICW2 = 3'b001;
  localparam logic [2:0] CMD_ICW3 = 3'b010;
  localparam logic [2:0] CMD_ICW4 = 3'b011;
  localparam logic [2:0] CMD_OCW1 = 3'b100;
  localparam logic [2:0] CMD_OCW2 = 3'b101;
  localparam logic [2:0] CMD_OCW3 = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } state_t;

  // ICW1 is recognised by A0=0 with D4 set, regardless of sequencer state.
  function automatic logic is_icw1(input logic a0, input logic [7:0] din);
    return (a0 == 1'b0) && din[4];
  endfunction

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU write port and command-forwarding outputs of the PIC command sequencer.
interface pic_cmd_sequencer_if;

  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data;
  logic       no_icw4;
  logic       sngl;
  logic       init_busy;
  logic       ready;
  logic       seq_err;

  modport master (
    output cs_n, wr_n, a0, din,
    input  cmd_valid, cmd_code, cmd_data, no_icw4, sngl, init_busy, ready, seq_err
  );

  modport slave (
    input  cs_n, wr_n, a0, din,
    output cmd_valid, cmd_code, cmd_data, no_icw4, sngl, init_busy, ready, seq_err
  );

endinterface

// File: rtl/pic_wr_edge.sv
// Input sampling stage: registers the CPU strobes/bus and flags a write on the
// first cycle wr_n is seen high after a chip-selected low sample.
module pic_wr_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cs_n,
  input  logic       i_wr_n,
  input  logic       i_a0,
  input  logic [7:0] i_din,
  output logic       o_wr_evt,
  output logic       o_a0_q,
  output logic [7:0] o_din_q
);

  logic       r_cs_q;
  logic       r_wr_q;
  logic       r_a0_q;
  logic [7:0] r_din_q;

  // wr_q resets high so a strobe interrupted by reset cannot complete later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_q  <= 1'b1;
      r_wr_q  <= 1'b1;
      r_a0_q  <= 1'b0;
      r_din_q <= 8'h00;
    end else begin
      r_cs_q  <= i_cs_n;
      r_wr_q  <= i_wr_n;
      r_a0_q  <= i_a0;
      r_din_q <= i_din;
    end
  end

  assign o_wr_evt = !r_wr_q && !r_cs_q && i_wr_n;
  assign o_a0_q   = r_a0_q;
  assign o_din_q  = r_din_q;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259A-style command sequencer: classifies CPU writes as ICW1-4 / OCW1-3,
// tracks the initialization sequence and forwards accepted commands.
import pic_pkg::*;

module pic_cmd_sequencer #(
  parameter bit CASCADE_EN = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  pic_cmd_sequencer_if.slave bus
);

  logic       w_wr_evt;
  logic       w_a0_q;
  logic [7:0] w_din_q;

  state_t     r_state;
  logic       r_cmd_valid;
  logic [2:0] r_cmd_code;
  logic [7:0] r_cmd_data;
  logic       r_no_icw4;
  logic       r_sngl;
  logic       r_seq_err;

  state_t     w_state_next;
  logic       w_cmd_valid_next;
  logic [2:0] w_cmd_code_next;
  logic [7:0] w_cmd_data_next;
  logic       w_no_icw4_next;
  logic       w_sngl_next;
  logic       w_seq_err_next;
  logic       w_emit;
  logic [2:0] w_emit_code;

  pic_wr_edge u_wr_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_cs_n   (bus.cs_n),
    .i_wr_n   (bus.wr_n),
    .i_a0     (bus.a0),
    .i_din    (bus.din),
    .o_wr_evt (w_wr_evt),
    .o_a0_q   (w_a0_q),
    .o_din_q  (w_din_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= CMD_ICW1;
      r_cmd_data  <= 8'h00;
      r_no_icw4   <= 1'b1;
      r_sngl      <= 1'b1;
      r_seq_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_code  <= w_cmd_code_next;
      r_cmd_data  <= w_cmd_data_next;
      r_no_icw4   <= w_no_icw4_next;
      r_sngl      <= w_sngl_next;
      r_seq_err   <= w_seq_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_no_icw4_next   = r_no_icw4;
    w_sngl_next      = r_sngl;
    w_seq_err_next   = 1'b0;
    w_emit           = 1'b0;
    w_emit_code      = CMD_ICW1;

    if (w_wr_evt) begin
      if (is_icw1(w_a0_q, w_din_q)) begin
        w_emit         = 1'b1;
        w_emit_code    = CMD_ICW1;
        w_no_icw4_next = ~w_din_q[0];
        w_sngl_next    = w_din_q[1];
        w_state_next   = ST_WAIT_ICW2;
      end else begin
        unique case (r_state)
          ST_IDLE: w_seq_err_next = 1'b1;
          ST_WAIT_ICW2: begin
            if (w_a0_q) begin
              w_emit      = 1'b1;
              w_emit_code = CMD_ICW2;
              if (!r_sngl && CASCADE_EN)
                w_state_next = ST_WAIT_ICW3;
              else if (!r_no_icw4)
                w_state_next = ST_WAIT_ICW4;
              else
                w_state_next = ST_READY;
            end else begin
              w_seq_err_next = 1'b1;
            end
          end
          ST_WAIT_ICW3: begin
            if (w_a0_q) begin
              w_emit       = 1'b1;
              w_emit_code  = CMD_ICW3;
              w_state_next = r_no_icw4 ? ST_READY : ST_WAIT_ICW4;
            end else begin
              w_seq_err_next = 1'b1;
            end
          end
          ST_WAIT_ICW4: begin
            if (w_a0_q) begin
              w_emit       = 1'b1;
              w_emit_code  = CMD_ICW4;
              w_state_next = ST_READY;
            end else begin
              w_seq_err_next = 1'b1;
            end
          end
          ST_READY: begin
            w_emit = 1'b1;
            if (w_a0_q)
              w_emit_code = CMD_OCW1;
            else if (w_din_q[3])
              w_emit_code = CMD_OCW3;
            else
              w_emit_code = CMD_OCW2;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
    end

    // Code and data hold between emitted commands.
    w_cmd_valid_next = w_emit;
    w_cmd_code_next  = w_emit ? w_emit_code : r_cmd_code;
    w_cmd_data_next  = w_emit ? w_din_q : r_cmd_data;
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.cmd_data  = r_cmd_data;
  assign bus.no_icw4   = r_no_icw4;
  assign bus.sngl      = r_sngl;
  assign bus.seq_err   = r_seq_err;
  assign bus.init_busy = (r_state == ST_WAIT_ICW2) || (r_state == ST_WAIT_ICW3) ||
                         (r_state == ST_WAIT_ICW4);
  assign bus.ready     = (r_state == ST_READY);

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Randomized and directed bench for pic_cmd_sequencer; two instances (cascade
// enabled / disabled) share one stimulus and are checked against a queue model.
module tb_pic_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;

  int errors = 0;
  int checks = 0;

  pic_cmd_sequencer_if bus0 ();
  pic_cmd_sequencer_if bus1 ();

  assign bus0.cs_n = cs_n;
  assign bus0.wr_n = wr_n;
  assign bus0.a0   = a0;
  assign bus0.din  = din;
  assign bus1.cs_n = cs_n;
  assign bus1.wr_n = wr_n;
  assign bus1.a0   = a0;
  assign bus1.din  = din;

  pic_cmd_sequencer #(.CASCADE_EN(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pic_cmd_sequencer #(.CASCADE_EN(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model k=0 has cascade enabled, k=1 disabled. After ICW1 the list of still
  // expected ICW codes is built; the part is ready once the list is consumed.
  logic       m_started [2];
  logic       m_no_icw4 [2];
  logic       m_sngl    [2];
  logic       m_valid   [2];
  logic       m_err     [2];
  logic [2:0] m_code    [2];
  logic [7:0] m_data    [2];
  logic [2:0] m_pend    [2][3];
  int         m_npend   [2];
  int         m_pidx    [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 1'b0; m_no_icw4[k] = 1'b1; m_sngl[k] = 1'b1;
      m_valid[k] = 1'b0; m_err[k] = 1'b0; m_code[k] = 3'd0; m_data[k] = 8'h00;
      m_npend[k] = 0; m_pidx[k] = 0;
    end
  endtask

  task automatic model_clear_pulses();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
    end
  endtask

  task automatic model_emit(input int k, input logic [2:0] code, input logic [7:0] d);
    m_valid[k] = 1'b1;
    m_code[k]  = code;
    m_data[k]  = d;
  endtask

  task automatic model_write(input logic wa0, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
      if (!wa0 && d[4]) begin
        m_started[k] = 1'b1;
        m_no_icw4[k] = ~d[0];
        m_sngl[k]    = d[1];
        m_npend[k]   = 0;
        m_pidx[k]    = 0;
        m_pend[k][m_npend[k]] = 3'd1; m_npend[k]++;
        if (k == 0 && !m_sngl[k]) begin
          m_pend[k][m_npend[k]] = 3'd2; m_npend[k]++;
        end
        if (!m_no_icw4[k]) begin
          m_pend[k][m_npend[k]] = 3'd3; m_npend[k]++;
        end
        model_emit(k, 3'd0, d);
      end else if (!m_started[k]) begin
        m_err[k] = 1'b1;
      end else if (m_pidx[k] < m_npend[k]) begin
        if (wa0) begin
          model_emit(k, m_pend[k][m_pidx[k]], d);
          m_pidx[k]++;
        end else begin
          m_err[k] = 1'b1;
        end
      end else begin
        if (wa0)       model_emit(k, 3'd4, d);
        else if (d[3]) model_emit(k, 3'd6, d);
        else           model_emit(k, 3'd5, d);
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic       ov, oe, on, os, ob, orr, eb, er;
      logic [2:0] oc;
      logic [7:0] od;
      if (k == 0) begin
        ov = bus0.cmd_valid; oe = bus0.seq_err; oc = bus0.cmd_code; od = bus0.cmd_data;
        on = bus0.no_icw4; os = bus0.sngl; ob = bus0.init_busy; orr = bus0.ready;
      end else begin
        ov = bus1.cmd_valid; oe = bus1.seq_err; oc = bus1.cmd_code; od = bus1.cmd_data;
        on = bus1.no_icw4; os = bus1.sngl; ob = bus1.init_busy; orr = bus1.ready;
      end
      eb = m_started[k] && (m_pidx[k] < m_npend[k]);
      er = m_started[k] && (m_pidx[k] == m_npend[k]);
      chk({tag, ".cmd_valid"}, k, {7'd0, ov}, {7'd0, m_valid[k]});
      chk({tag, ".seq_err"},   k, {7'd0, oe}, {7'd0, m_err[k]});
      chk({tag, ".cmd_code"},  k, {5'd0, oc}, {5'd0, m_code[k]});
      chk({tag, ".cmd_data"},  k, od, m_data[k]);
      chk({tag, ".no_icw4"},   k, {7'd0, on}, {7'd0, m_no_icw4[k]});
      chk({tag, ".sngl"},      k, {7'd0, os}, {7'd0, m_sngl[k]});
      chk({tag, ".init_busy"}, k, {7'd0, ob}, {7'd0, eb});
      chk({tag, ".ready"},     k, {7'd0, orr}, {7'd0, er});
    end
  endtask

  // One write: low phase for one sample, high phase for one sample.
  // cs_hi keeps chip select inactive during the low phase (no event expected);
  // cs_rise deasserts chip select together with the rising write strobe.
  task automatic do_write(input string tag, input logic wa0, input logic [7:0] d,
                          input bit cs_hi, input bit cs_rise, input bit fast);
    @(negedge clk);
    cs_n = cs_hi; wr_n = 1'b0; a0 = wa0; din = d;
    @(negedge clk);
    wr_n = 1'b1;
    if (cs_rise) cs_n = 1'b1;
    a0  = ~wa0;
    din = 8'($urandom);
    @(posedge clk); #1;
    if (cs_hi) model_clear_pulses();
    else       model_write(wa0, d);
    $display("wr %s a0=%0d din=%02h cs_hi=%0d cs_rise=%0d -> dut0 v=%0d c=%0d d=%02h e=%0d | dut1 v=%0d c=%0d d=%02h e=%0d",
             tag, wa0, d, cs_hi, cs_rise, bus0.cmd_valid, bus0.cmd_code, bus0.cmd_data, bus0.seq_err,
             bus1.cmd_valid, bus1.cmd_code, bus1.cmd_data, bus1.seq_err);
    check_outputs(tag);
    if (!fast) begin
      @(posedge clk); #1;
      model_clear_pulses();
      check_outputs({tag, ".after"});
    end
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post_reset");

    do_write("idle_bad", 1'b1, 8'hFF, 0, 0, 0);

    do_write("icw1_13", 1'b0, 8'h13, 0, 0, 0);
    do_write("icw2_a8", 1'b1, 8'hA8, 0, 0, 0);
    do_write("icw4_03", 1'b1, 8'h03, 0, 0, 0);

    do_write("ocw1_02", 1'b1, 8'h02, 0, 0, 0);
    do_write("ocw2_20", 1'b0, 8'h20, 0, 0, 0);
    do_write("ocw3_0b", 1'b0, 8'h0B, 0, 0, 0);

    do_write("icw1_11", 1'b0, 8'h11, 0, 0, 0);
    do_write("casc_w1", 1'b1, 8'h40, 0, 0, 0);
    do_write("casc_w2", 1'b1, 8'h04, 0, 0, 0);
    do_write("casc_w3", 1'b1, 8'h01, 0, 0, 0);

    do_write("icw1_11b", 1'b0, 8'h11, 0, 0, 0);
    do_write("w2_bad",   1'b0, 8'h20, 0, 0, 0);
    do_write("w2_icw2",  1'b1, 8'h08, 0, 0, 0);
    do_write("w3_icw1",  1'b0, 8'h1B, 0, 0, 0);
    do_write("w2_again", 1'b1, 8'h10, 0, 0, 0);

    do_write("cs_hi",    1'b1, 8'h77, 1, 0, 0);

    do_write("b2b_0", 1'b0, 8'h12, 0, 0, 1);
    do_write("b2b_1", 1'b1, 8'h30, 0, 1, 1);
    do_write("b2b_2", 1'b1, 8'h31, 0, 0, 1);
    do_write("b2b_3", 1'b0, 8'h08, 0, 1, 1);
    do_write("b2b_4", 1'b0, 8'h0A, 0, 0, 0);

    // Reset while the write strobe is low: nothing may fire afterwards.
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h55;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    model_reset();
    check_outputs("rst_midwrite");
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outputs("rst_release");
    end
    $display("rst mid-write -> dut0 v=%0d e=%0d busy=%0d", bus0.cmd_valid, bus0.seq_err, bus0.init_busy);

    for (int n = 0; n < 300; n++) begin
      logic       ra0;
      logic [7:0] rd;
      if ($urandom_range(0, 3) == 0) begin
        ra0 = 1'b0;
        rd  = 8'($urandom) | 8'h10;
      end else begin
        ra0 = 1'($urandom);
        rd  = 8'($urandom);
      end
      do_write("rand", ra0, rd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
               1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
